// File: rtl/channel_accum_tree.sv
`default_nettype none
// ============================================================================
// Module      : channel_accum_tree
// Description : Sums NUM_IN signed products per beat with an adder tree,
//               accumulates ACC_CH beats plus a bias, then applies optional
//               ReLU and saturation before presenting one result through a
//               valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_accum_tree #(
   parameter int DATA_W  = 16,
   parameter int NUM_IN  = 9,
   parameter int ACC_CH  = 8,
   parameter int SAT_EN  = 1,
   parameter int RELU_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0]        bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     busy
);

   // Wide enough that NUM_IN*ACC_CH full-scale operands plus the bias never wrap.
   localparam int ACC_W  = DATA_W + $clog2(NUM_IN * ACC_CH) + 1;
   localparam int CNT_W  = (ACC_CH > 1) ? $clog2(ACC_CH) : 1;
   localparam int LEAVES = 1 << $clog2(NUM_IN);
   localparam int NODES  = 2 * LEAVES - 1;

   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(ACC_CH - 1);
   localparam logic signed [ACC_W-1:0] MAX_V    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V    = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [CNT_W-1:0]          cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   node [NODES];
   logic signed [ACC_W-1:0]   beat_sum;
   logic signed [ACC_W-1:0]   total;
   logic [DATA_W-1:0]         result;
   logic                      transfer;
   logic                      last_beat;

   // Balanced adder tree: leaves hold sign-extended operands (zero padded to a
   // power of two), each internal node adds its two children, root is node 0.
   always_comb begin
      for (int i = 0; i < NODES; i++) begin
         node[i] = '0;
      end
      for (int i = 0; i < NUM_IN; i++) begin
         node[LEAVES-1+i] = ACC_W'($signed(in_data[i*DATA_W +: DATA_W]));
      end
      for (int i = LEAVES - 2; i >= 0; i--) begin
         node[i] = node[2*i+1] + node[2*i+2];
      end
   end

   assign beat_sum  = node[0];
   assign transfer  = in_valid && in_ready;
   assign last_beat = (cnt == LAST_CNT);
   // The first beat of a result restarts from the bias instead of the old total.
   assign total     = ((cnt == '0) ? ACC_W'($signed(bias)) : acc) + beat_sum;

   // Post-processing: ReLU first, then saturation, else truncation; the
   // truncate-then-ReLU case keeps the legacy "negative after wrap gives 0".
   always_comb begin
      result = total[DATA_W-1:0];
      if ((RELU_EN != 0) && (total < 0)) begin
         result = '0;
      end else if ((SAT_EN != 0) && (total > MAX_V)) begin
         result = MAX_V[DATA_W-1:0];
      end else if ((SAT_EN != 0) && (RELU_EN == 0) && (total < MIN_V)) begin
         result = MIN_V[DATA_W-1:0];
      end else if ((SAT_EN == 0) && (RELU_EN != 0) && total[DATA_W-1]) begin
         result = '0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; flush always returns to accumulation.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_ACC: begin
            in_ready = 1'b1;
            if (transfer && last_beat) begin
               state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_ACC;
            end
         end
         default: state_nxt = ST_ACC;
      endcase
      if (flush) begin
         state_nxt = ST_ACC;
      end
   end

   // Beat counter, accumulator and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         out_data <= '0;
      end else if (flush) begin
         cnt <= '0;
         acc <= '0;
      end else if (transfer) begin
         acc <= total;
         if (last_beat) begin
            cnt      <= '0;
            out_data <= result;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign busy = (cnt != '0) || out_valid;

endmodule
`default_nettype wire

// File: tb/tb_channel_accum_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_accum_tree
// Description : Self-checking bench for channel_accum_tree. Four instances
//               (default, no ReLU, no saturation, single-channel) share one
//               stimulus stream; a per-instance result scoreboard runs beside
//               table-driven and hand-written directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_accum_tree;

   localparam int DW   = 16;
   localparam int NI   = 9;
   localparam int NDUT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              out_ready;
   logic [NI*DW-1:0]  in_data;
   logic [DW-1:0]     bias;
   logic              in_ready_v  [NDUT];
   logic              out_valid_v [NDUT];
   logic              busy_v      [NDUT];
   logic [DW-1:0]     out_data_v  [NDUT];

   int tests = 0;
   int fails = 0;
   int results = 0;

   int acc_ch_c [NDUT] = '{8, 8, 8, 1};
   bit sat_c    [NDUT] = '{1'b1, 1'b1, 1'b0, 1'b1};
   bit relu_c   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};

   // Free-running clock.
   always #5 clk = ~clk;

   channel_accum_tree #(.DATA_W(DW), .NUM_IN(NI), .ACC_CH(8), .SAT_EN(1), .RELU_EN(1)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[0]),
      .in_data(in_data), .bias(bias), .out_valid(out_valid_v[0]), .out_ready(out_ready),
      .out_data(out_data_v[0]), .busy(busy_v[0]));
   channel_accum_tree #(.DATA_W(DW), .NUM_IN(NI), .ACC_CH(8), .SAT_EN(1), .RELU_EN(0)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[1]),
      .in_data(in_data), .bias(bias), .out_valid(out_valid_v[1]), .out_ready(out_ready),
      .out_data(out_data_v[1]), .busy(busy_v[1]));
   channel_accum_tree #(.DATA_W(DW), .NUM_IN(NI), .ACC_CH(8), .SAT_EN(0), .RELU_EN(1)) u_dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[2]),
      .in_data(in_data), .bias(bias), .out_valid(out_valid_v[2]), .out_ready(out_ready),
      .out_data(out_data_v[2]), .busy(busy_v[2]));
   channel_accum_tree #(.DATA_W(DW), .NUM_IN(NI), .ACC_CH(1), .SAT_EN(1), .RELU_EN(1)) u_dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[3]),
      .in_data(in_data), .bias(bias), .out_valid(out_valid_v[3]), .out_ready(out_ready),
      .out_data(out_data_v[3]), .busy(busy_v[3]));

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference post-processing from the arithmetic rules on a wide total.
   function automatic longint post(input longint t, input bit sat, input bit relu);
      longint lo;
      if (relu && t < 0) return 0;
      if (sat && t > 32767) return 32767;
      if (sat && !relu && t < -32768) return -32768;
      lo = t & 64'hFFFF;
      if (lo > 32767) lo = lo - 65536;
      if (!sat && relu && lo < 0) return 0;
      return lo;
   endfunction

   // Scoreboard: at most one held result per instance; a beat is taken only
   // while nothing is held. Checks current outputs, then applies this edge.
   bit     mon_en = 1'b0;
   int     cnt_m  [NDUT] = '{default: 0};
   longint sum_m  [NDUT] = '{default: 0};
   bit     held_m [NDUT] = '{default: 1'b0};
   longint val_m  [NDUT] = '{default: 0};

   always @(negedge clk) begin
      if (mon_en) begin
         longint beat;
         beat = 0;
         for (int k = 0; k < NI; k++) beat += longint'($signed(in_data[k*DW +: DW]));
         for (int d = 0; d < NDUT; d++) begin
            check($sformatf("mon%0d valid/ready/busy", d),
                  {out_valid_v[d], in_ready_v[d], busy_v[d]},
                  {held_m[d], !held_m[d], held_m[d] || (cnt_m[d] != 0)});
            if (held_m[d] && out_valid_v[d] === 1'b1)
               check($sformatf("mon%0d out_data", d), $signed(out_data_v[d]), val_m[d]);
            if (rst || flush) begin
               cnt_m[d]  = 0;
               held_m[d] = 1'b0;
            end else if (held_m[d]) begin
               if (out_ready) begin
                  held_m[d] = 1'b0;
                  results++;
               end
            end else if (in_valid) begin
               sum_m[d] = ((cnt_m[d] == 0) ? longint'($signed(bias)) : sum_m[d]) + beat;
               cnt_m[d]++;
               if (cnt_m[d] == acc_ch_c[d]) begin
                  val_m[d]  = post(sum_m[d], sat_c[d], relu_c[d]);
                  held_m[d] = 1'b1;
                  cnt_m[d]  = 0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beats(input logic [DW-1:0] v, input logic [DW-1:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = {NI{v}};
         bias     = b;
         check("in_ready during beat", in_ready_v[0], 1);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic run_result(input string nm, input logic [DW-1:0] v, input logic [DW-1:0] b,
                             input longint e0, input longint e1, input longint e2);
      longint exp [3];
      exp = '{e0, e1, e2};
      out_ready = 1'b1;
      beats(v, b, 8);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s valid d%0d", nm, d), out_valid_v[d], 1);
         check($sformatf("%s data d%0d", nm, d), $signed(out_data_v[d]), exp[d]);
      end
      step();
      check({nm, " valid one cycle"}, out_valid_v[0], 0);
   endtask

   typedef struct {
      string       nm;
      logic [15:0] v;
      logic [15:0] b;
      longint      e0;
      longint      e1;
      longint      e2;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{"basic",     16'd1,      16'd3,    75,    75,     75};
      tbl[1] = '{"relu",     -16'sd1,     16'd0,     0,   -72,      0};
      tbl[2] = '{"sat pos",   16'd4000,   16'd0, 32767, 32767,  25856};
      tbl[3] = '{"sat neg",  -16'sd4000,  16'd0,     0, -32768,     0};
      tbl[4] = '{"bias neg",  16'd100,   -16'sd5, 7195,  7195,   7195};
      tbl[5] = '{"wrap pos",  16'd3641,   16'd0, 32767, 32767,      8};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; bias = '0;
      step();
      mon_en = 1'b1;
      step();
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset out_valid d%0d", d), out_valid_v[d], 0);
         check($sformatf("reset out_data d%0d", d), out_data_v[d], 0);
         check($sformatf("reset busy d%0d", d), busy_v[d], 0);
      end
      rst = 1'b0;
      check("in_ready after reset", in_ready_v[0], 1);

      for (int i = 0; i < 6; i++) begin
         run_result(tbl[i].nm, tbl[i].v, tbl[i].b, tbl[i].e0, tbl[i].e1, tbl[i].e2);
      end

      // Backpressure: result held for 5 cycles, offered beats must be ignored.
      out_ready = 1'b0;
      beats(16'd1, 16'd3, 8);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = {NI{16'd2}};
         check("bp valid", out_valid_v[0], 1);
         check("bp data", $signed(out_data_v[0]), 75);
         check("bp in_ready", in_ready_v[0], 0);
         step();
      end
      out_ready = 1'b1;
      check("bp handshake in_ready", in_ready_v[0], 0);
      step();
      in_valid = 1'b0;
      check("bp after valid", out_valid_v[0], 0);
      check("bp beat not consumed", busy_v[0], 0);
      run_result("after bp", 16'd2, 16'd0, 144, 144, 144);

      // Flush mid-accumulation with a same-cycle beat.
      beats(16'd5, 16'd0, 3);
      check("busy mid acc", busy_v[0], 1);
      flush = 1'b1; in_valid = 1'b1; in_data = {NI{16'd5}};
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush busy", busy_v[0], 0);
      check("flush valid", out_valid_v[0], 0);
      run_result("after flush", 16'd1, 16'd0, 72, 72, 72);

      // Flush while holding a result, beating a same-cycle handshake.
      out_ready = 1'b0;
      beats(16'd1, 16'd3, 8);
      check("held before flush", out_valid_v[0], 1);
      flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0;
      check("flush drops result", out_valid_v[0], 0);
      check("flush out busy", busy_v[0], 0);
      run_result("after out flush", 16'd7, 16'd2, 506, 506, 506);

      // Reset while holding a result.
      out_ready = 1'b0;
      beats(16'd1, 16'd3, 8);
      check("held before rst", out_valid_v[0], 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst in out valid d%0d", d), out_valid_v[d], 0);
         check($sformatf("rst in out data d%0d", d), out_data_v[d], 0);
      end
      check("in_ready after rst", in_ready_v[0], 1);
      run_result("after rst", 16'd1, 16'd3, 75, 75, 75);

      // Random stress, checked by the scoreboard.
      for (int c = 0; c < 40000; c++) begin
         rst       = ($urandom_range(0, 1999) == 0);
         flush     = ($urandom_range(0, 499) == 0);
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         bias      = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16) - 8);
         for (int k = 0; k < NI; k++) begin
            in_data[k*DW +: DW] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16) - 8);
         end
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      mon_en = 1'b0;
      check("random results > 10000", results > 10000, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/channel_accum_tree.md
CHANNEL_ACCUM_TREE -- requirements
Module: channel_accum_tree

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the signed width of each operand, the bias and the result.
REQ-002 SHALL have parameter NUM_IN, default 9, meaning the number of signed products summed per beat (kernel taps).
REQ-003 SHALL have parameter ACC_CH, default 8, range 1..256, meaning the number of beats (input channels) accumulated per result.
REQ-004 SHALL have parameter SAT_EN, default 1: 1 saturates the positive result to DATA_W, 0 truncates it to the low DATA_W bits.
REQ-005 SHALL have parameter RELU_EN, default 1: 1 clamps a negative result to 0, 0 passes it through.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-008 SHALL have port flush, input, 1 bit, synchronous abort of the current accumulation.
REQ-009 SHALL have port in_valid, input, 1 bit, meaning a beat is offered.
REQ-010 SHALL have port in_ready, output, 1 bit, meaning a beat is accepted this cycle.
REQ-011 SHALL have port in_data, input, NUM_IN*DATA_W bits, carrying packed signed operands, with operand k in bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port bias, input, DATA_W bits, a signed bias sampled on the first beat of each result.
REQ-013 SHALL have port out_valid, output, 1 bit, meaning a result is held.
REQ-014 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-015 SHALL have port out_data, output, DATA_W bits, the signed result.
REQ-016 SHALL have port busy, output, 1 bit, high when beat count is nonzero or out_valid is high.

Function
REQ-017 Internal accumulator width ACC_W SHALL be DATA_W + clog2(NUM_IN*ACC_CH) + 1 bits; all sums SHALL be sign-extended to ACC_W, with no intermediate overflow.
REQ-018 Beat sum SHALL be the combinational signed sum of all NUM_IN operands; any balanced tree is allowed.
REQ-019 The FSM SHALL have two states: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-020 Beat transfer SHALL occur on a cycle with in_valid && in_ready.
REQ-021 On a transfer with cnt==0, the accumulator SHALL load sext(bias) + beat sum; on other transfers it SHALL add the beat sum; cnt SHALL increment.
REQ-022 On the transfer with cnt==ACC_CH-1: cnt -> 0, the post-processed result is registered into out_data, and the state goes to OUT; out_valid SHALL be high the next cycle (latency 1 cycle after the last beat).
REQ-023 Post-processing SHALL be applied in order: (a) if RELU_EN and total<0, then 0; (b) else if SAT_EN and total>2^(DATA_W-1)-1, then 2^(DATA_W-1)-1; (c) else if SAT_EN and !RELU_EN and total<-2^(DATA_W-1), then -2^(DATA_W-1); (d) else the low DATA_W bits of the total.
REQ-024 When SAT_EN=0 and RELU_EN=1, after truncation a result with bit DATA_W-1 set SHALL output 0 (legacy behaviour).
REQ-025 In OUT, out_data SHALL be stable until out_valid && out_ready; then the state goes to ACC; in_ready SHALL remain 0 during that handshake cycle.
REQ-026 With ACC_CH=1, every accepted beat SHALL produce a result.
REQ-027 Beats with in_valid=0 SHALL leave cnt and the accumulator unchanged; gaps are allowed anywhere.
REQ-028 flush SHALL set cnt=0, clear the accumulator, go to ACC and drop any held result (out_valid=0 next cycle).
REQ-029 flush SHALL take priority over a same-cycle beat transfer or output handshake; that beat is discarded.
REQ-030 Throughput SHALL be one result per ACC_CH+1 cycles maximum.

Reset
REQ-031 rst SHALL take priority over flush and all handshakes.
REQ-032 On rst, state=ACC, cnt=0, accumulator=0, out_data=0, out_valid=0, busy=0 at the next edge; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 rst mid-accumulation or in OUT SHALL discard all partial and held data.

Verification (NUM_IN=9, ACC_CH=8, DATA_W=16 unless stated)
REQ-034 Basic: 8 beats of all operands=1 back-to-back, bias=3, out_ready=1 -> out_data=75, out_valid high exactly 1 cycle, the cycle after beat 8.
REQ-035 ReLU: all operands=-1, bias=0 -> out_data=0; repeated with RELU_EN=0 -> out_data=-72.
REQ-036 Saturation: all operands=4000, bias=0 -> out_data=32767; with SAT_EN=0 -> out_data=25856 (288000 mod 65536).
REQ-037 Backpressure: result 75 with out_ready low for 5 cycles -> out_data stays 75, in_ready=0, offered beats are not consumed; the next result is correct after out_ready rises.
REQ-038 Flush/reset: flush after 3 beats, then 8 beats of 1 with bias=0 -> 72; rst asserted in OUT -> out_valid=0 and out_data=0 next cycle, and the subsequent result is unaffected.
REQ-039 Random stress: random in_valid/out_ready gaps and operands, checked against a wide-integer reference model, for more than 10k results.
